// File: rtl/uart_receive.sv
// UART receiver: 1 start bit, D_WIDTH data bits LSB first, 1 stop bit; valid/ready delivery.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer before the FSM.
module uart_receive #(
  parameter int unsigned D_WIDTH      = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               rx_ready,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_busy,
  output logic               rx_err,
  output logic               rx_overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BitW = $clog2(D_WIDTH + 1);
  localparam int unsigned Half = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'((Half == 0) ? 0 : Half - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(D_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  // With no half-bit delay the start bit is already confirmed at detection.
  localparam state_e StFirst = (Half == 0) ? StData : StStart;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [BitW-1:0]    bit_cnt_q;
  logic [D_WIDTH-1:0] shift_q;
  logic               stop_done_q;
  logic               stop_ok_q;
  logic               rx_s;
  logic [D_WIDTH:0]   shift_ext;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  // New bit enters at the MSB; after D_WIDTH shifts bit 0 sits at the LSB.
  assign shift_ext = {rx_s, shift_q};
  assign rx_busy   = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      stop_done_q <= 1'b0;
      stop_ok_q   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      rx_err     <= 1'b0;
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= StFirst;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            state_q <= rx_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            shift_q <= shift_ext[D_WIDTH:1];
            if (bit_cnt_q == BitLast) begin
              state_q <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (!stop_done_q) begin
            if (cnt_q == CntLast) begin
              cnt_q       <= '0;
              stop_done_q <= 1'b1;
              stop_ok_q   <= rx_s;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            // Delivery cycle; it also acts as IDLE so back-to-back starts are caught.
            stop_done_q <= 1'b0;
            bit_cnt_q   <= '0;
            if (stop_ok_q) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
              state_q <= rx_s ? StIdle : StFirst;
            end else begin
              rx_err  <= 1'b1;
              state_q <= StWaitHigh;
            end
          end
        end
        StWaitHigh: begin
          if (rx_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: frame-level reference model (scan of the line) vs. two DUTs
// (CLKS_PER_BIT 1 and 4); honours UART_RX_SYNC_EN by delaying the modelled line.
module tb_uart_receive;
  localparam int D    = 8;
  localparam int MAXN = 2048;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx1 = 1'b1, rdy1 = 1'b0, rx4 = 1'b1, rdy4 = 1'b0;
  logic [D-1:0] data1, data4;
  logic valid1, busy1, err1, ovr1, valid4, busy4, err4, ovr4;

  always #5 clk = ~clk;

  uart_receive #(.D_WIDTH(D), .CLKS_PER_BIT(1)) u_c1 (
    .clk(clk), .rst(rst), .rx(rx1), .rx_ready(rdy1), .rx_data(data1),
    .rx_valid(valid1), .rx_busy(busy1), .rx_err(err1), .rx_overrun(ovr1)
  );

  uart_receive #(.D_WIDTH(D), .CLKS_PER_BIT(4)) u_c4 (
    .clk(clk), .rst(rst), .rx(rx4), .rx_ready(rdy4), .rx_data(data4),
    .rx_valid(valid4), .rx_busy(busy4), .rx_err(err4), .rx_overrun(ovr4)
  );

  int errors = 0;
  int checks = 0;

  bit pin[MAXN];
  bit rdy[MAXN];
  int wp;

  bit           fl[MAXN];
  bit           m_dl[MAXN];
  logic [D-1:0] m_dd[MAXN];
  bit           e_valid[MAXN], e_busy[MAXN], e_err[MAXN], e_ovr[MAXN];
  logic [D-1:0] e_data[MAXN];

  int m_ndel, m_first_del, m_nerr, m_nov;
  logic [D-1:0] m_first_data;

  int o_first_valid, o_valid_cnt, o_first_err, o_err_cnt, o_busy_cnt, o_ovr_cnt, o_ovr_first;

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s @%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic put(input bit v, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (wp < MAXN) begin
        pin[wp] = v;
        wp++;
      end
    end
  endtask

  task automatic put_frame(input logic [D-1:0] d, input bit stop, input int c);
    put(1'b0, c);
    for (int i = 0; i < D; i++) put(d[i], c);
    put(stop, c);
  endtask

  task automatic set_rdy(input int from, input bit v);
    for (int k = from; k < MAXN; k++) rdy[k] = v;
  endtask

  function automatic bit fv(input int i, input int n);
    return (i < n) ? fl[i] : 1'b1;
  endfunction

  task automatic mark_busy(input int a, input int b, input int n);
    for (int k = a; k <= b; k++) if (k >= 0 && k < n) e_busy[k] = 1'b1;
  endtask

  // Frame-level reference: locate starts on the line as the FSM sees it, then apply handshake.
  task automatic build_model(input int c, input int n);
    int h, k, t, s, m;
    logic [D-1:0] w;
    bit valid, vb;
    logic [D-1:0] data;
    h = (c - 1) / 2;
    for (int i = 0; i < n; i++) begin
      fl[i]     = (i >= SYNC) ? pin[i - SYNC] : 1'b1;
      m_dl[i]   = 1'b0;
      m_dd[i]   = '0;
      e_busy[i] = 1'b0;
      e_err[i]  = 1'b0;
    end
    k = 0;
    while (k < n) begin
      if (fv(k, n)) begin
        k++;
        continue;
      end
      t = k;
      if (h > 0 && fv(t + h, n)) begin
        mark_busy(t, t + h - 1, n);
        k = t + h + 1;
        continue;
      end
      s = t + h + (D + 1) * c;
      for (int i = 0; i < D; i++) w[i] = fv(t + h + (i + 1) * c, n);
      mark_busy(t, s, n);
      if (fv(s, n)) begin
        if (s + 1 < n) begin
          m_dl[s + 1] = 1'b1;
          m_dd[s + 1] = w;
        end
        k = s + 1;
      end else begin
        if (s + 1 < n) e_err[s + 1] = 1'b1;
        m = s + 2;
        while (m < n && !fv(m, n)) m++;
        mark_busy(s + 1, m - 1, n);
        k = m + 1;
      end
    end
    valid = 1'b0;
    data  = '0;
    m_ndel = 0; m_first_del = -1; m_first_data = '0; m_nerr = 0; m_nov = 0;
    for (int i = 0; i < n; i++) begin
      vb       = valid;
      e_ovr[i] = 1'b0;
      if (valid && rdy[i]) valid = 1'b0;
      if (m_dl[i]) begin
        if (!vb || rdy[i]) begin
          data  = m_dd[i];
          valid = 1'b1;
          if (m_ndel == 0) begin
            m_first_del  = i;
            m_first_data = m_dd[i];
          end
          m_ndel++;
        end else begin
          e_ovr[i] = 1'b1;
          m_nov++;
        end
      end
      if (e_err[i]) m_nerr++;
      e_valid[i] = valid;
      e_data[i]  = data;
    end
  endtask

  task automatic do_reset();
    rx1 = 1'b1; rx4 = 1'b1; rdy1 = 1'b0; rdy4 = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_seg(input int sel, input int n);
    logic [D-1:0] d;
    bit v, b, e, o;
    build_model(sel ? 4 : 1, n);
    do_reset();
    d = sel ? data4 : data1;
    check("reset_valid", -1, {31'b0, sel ? valid4 : valid1}, 32'd0);
    check("reset_busy", -1, {31'b0, sel ? busy4 : busy1}, 32'd0);
    check("reset_data", -1, {24'b0, d}, 32'd0);
    rst = 1'b0;
    o_first_valid = -1; o_valid_cnt = 0; o_first_err = -1; o_err_cnt = 0;
    o_busy_cnt = 0; o_ovr_cnt = 0; o_ovr_first = -1;
    for (int k = 0; k < n; k++) begin
      if (sel) begin
        rx4 = pin[k]; rdy4 = rdy[k];
      end else begin
        rx1 = pin[k]; rdy1 = rdy[k];
      end
      @(posedge clk);
      #1;
      v = sel ? valid4 : valid1;
      b = sel ? busy4 : busy1;
      e = sel ? err4 : err1;
      o = sel ? ovr4 : ovr1;
      d = sel ? data4 : data1;
      check("rx_valid", k, {31'b0, v}, {31'b0, e_valid[k]});
      check("rx_data", k, {24'b0, d}, {24'b0, e_data[k]});
      check("rx_busy", k, {31'b0, b}, {31'b0, e_busy[k]});
      check("rx_err", k, {31'b0, e}, {31'b0, e_err[k]});
      check("rx_overrun", k, {31'b0, o}, {31'b0, e_ovr[k]});
      if (v) begin
        if (o_first_valid < 0) o_first_valid = k;
        o_valid_cnt++;
      end
      if (e) begin
        if (o_first_err < 0) o_first_err = k;
        o_err_cnt++;
      end
      if (o) begin
        if (o_ovr_first < 0) o_ovr_first = k;
        o_ovr_cnt++;
      end
      if (b) o_busy_cnt++;
    end
    rx1 = 1'b1; rx4 = 1'b1;
  endtask

  task automatic gen_random(input int c, input int rdy_pct);
    bit stop;
    wp = 0;
    put(1'b1, $urandom_range(1, 5));
    while (wp < MAXN - 200) begin
      if (c > 1 && $urandom_range(0, 9) == 0) begin
        put(1'b0, 1);
        put(1'b1, $urandom_range(2, 6));
      end else begin
        stop = ($urandom_range(0, 9) != 0);
        put_frame(D'($urandom), stop, c);
        if (!stop) put(1'b0, $urandom_range(0, 6));
        put(1'b1, (c == 1) ? $urandom_range(0, 3) : $urandom_range(0, 5));
      end
    end
    put(1'b1, 100);
    for (int k = 0; k < MAXN; k++) rdy[k] = ($urandom_range(0, 99) < rdy_pct);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // 0xA5, one bit per clock, consumer always ready
    wp = 0; put(1'b1, 5); put_frame(8'hA5, 1'b1, 1); put(1'b1, 20); set_rdy(0, 1'b1);
    t = 5 + SYNC;
    run_seg(0, wp);
    check("m_a5_rise", 0, m_first_del, t + 10);
    check("m_a5_data", 0, {24'b0, m_first_data}, 32'hA5);
    check("a5_rise", 0, o_first_valid, t + 10);
    check("a5_valid_cycles", 0, o_valid_cnt, 1);
    check("a5_busy_cycles", 0, o_busy_cnt, 10);
    check("a5_no_err", 0, o_err_cnt, 0);

    // 0xA5 at 4 clocks per bit, then a single-cycle glitch
    wp = 0; put(1'b1, 5); put_frame(8'hA5, 1'b1, 4); put(1'b1, 20); put(1'b0, 1); put(1'b1, 30);
    set_rdy(0, 1'b1);
    run_seg(1, wp);
    check("m_c4_rise", 1, m_first_del, t + 38);
    check("m_c4_ndel", 1, m_ndel, 1);
    check("c4_rise", 1, o_first_valid, t + 38);
    check("c4_valid_cycles", 1, o_valid_cnt, 1);
    check("c4_busy_cycles", 1, o_busy_cnt, 39);

    // 0x5A with a bad stop bit and a held-low break
    wp = 0; put(1'b1, 5); put_frame(8'h5A, 1'b0, 1); put(1'b0, 5); put(1'b1, 20);
    set_rdy(0, 1'b1);
    run_seg(0, wp);
    check("m_err_count", 2, m_nerr, 1);
    check("err_rise", 2, o_first_err, t + 10);
    check("err_pulses", 2, o_err_cnt, 1);
    check("err_no_valid", 2, o_valid_cnt, 0);
    check("err_busy_cycles", 2, o_busy_cnt, 15);

    // Overrun: 0x11 then 0x22 back-to-back with consumer stalled, then ready
    wp = 0; put(1'b1, 5); put_frame(8'h11, 1'b1, 1); put_frame(8'h22, 1'b1, 1); put(1'b1, 10);
    set_rdy(0, 1'b0); set_rdy(wp, 1'b1); put(1'b1, 10);
    run_seg(0, wp);
    check("m_ovr_count", 3, m_nov, 1);
    check("ovr_pulses", 3, o_ovr_cnt, 1);
    check("ovr_cycle", 3, o_ovr_first, t + 20);
    check("ovr_valid_cycles", 3, o_valid_cnt, 20 - SYNC);
    check("ovr_data_kept", 3, {24'b0, data1}, 32'h11);

    // Reset in the middle of a 0xFF frame while an older word is pending
    do_reset();
    rst = 1'b0;
    wp = 0; put(1'b1, 3); put_frame(8'h3C, 1'b1, 1); put(1'b1, 5); put(1'b0, 1); put(1'b1, 4);
    for (int k = 0; k < wp; k++) begin
      rx1 = pin[k];
      @(posedge clk);
      #1;
    end
    check("pre_rst_valid", 4, {31'b0, valid1}, 32'd1);
    check("pre_rst_data", 4, {24'b0, data1}, 32'h3C);
    check("pre_rst_busy", 4, {31'b0, busy1}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 4, {31'b0, valid1}, 32'd0);
    check("mid_rst_busy", 4, {31'b0, busy1}, 32'd0);
    check("mid_rst_data", 4, {24'b0, data1}, 32'd0);
    check("mid_rst_err", 4, {30'b0, err1, ovr1}, 32'd0);
    wp = 0; put(1'b1, 3); put_frame(8'h0F, 1'b1, 1); put(1'b1, 15); set_rdy(0, 1'b1);
    run_seg(0, wp);
    check("post_rst_data", 5, {24'b0, m_first_data}, 32'h0F);
    check("post_rst_rise", 5, o_first_valid, 3 + SYNC + 10);

    // Transmitter-style 0x3C frame
    wp = 0; put(1'b1, 3); put_frame(8'h3C, 1'b1, 1); put(1'b1, 15); set_rdy(0, 1'b1);
    run_seg(0, wp);
    check("loop_rise", 6, o_first_valid, 3 + SYNC + 10);
    check("loop_valid_cycles", 6, o_valid_cnt, 1);
    check("loop_err_ovr", 6, o_err_cnt + o_ovr_cnt, 0);

    // Randomized streams at both bit rates and several consumer duty cycles
    for (int r = 0; r < 3; r++) begin
      gen_random(1, (r == 0) ? 90 : (r == 1) ? 50 : 10);
      run_seg(0, wp);
      gen_random(4, (r == 0) ? 90 : (r == 1) ? 50 : 5);
      run_seg(1, wp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
